// File: rtl/piso_pkg.sv
// Shared types and frame-length helper for the PISO transmitter.
// Frame length grows by one parity bit when PISO_PARITY_EN is defined.
package piso_pkg;

    typedef enum logic {IDLE, SHIFT} piso_state_t;

    function automatic int frame_len(input int width);
`ifdef PISO_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage

// File: rtl/piso_tx_serializer.sv
// Parallel-in/serial-out transmitter feeding siso_reg; optional even parity via PISO_PARITY_EN.
// Latency: first bit on serial_out one cycle after the accepting edge; back-to-back frames have no gap.
// Backpressure: load_ready decodes registered state only; high when idle or on the last bit of a frame.
module piso_tx_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             frame_active,
    output logic             done
);

    localparam int FRAME_LEN = frame_len(WIDTH);
    localparam int CW        = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

    piso_state_t      state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             last_bit;
    logic             accept;
    logic             first_bit;
    logic             next_bit;
    logic [WIDTH-1:0] load_rest;
    logic [WIDTH-1:0] shift_rest;

`ifdef PISO_PARITY_EN
    localparam logic [CW-1:0] DATA_LAST = CW'(WIDTH - 1);
    logic parity;
`endif

    always_comb begin
        last_bit     = (state == SHIFT) && (cnt == LAST_IDX);
        load_ready   = (state == IDLE) || last_bit;
        accept       = load_valid && load_ready;
        frame_active = (state == SHIFT);
        done         = last_bit;
    end

    // shreg holds the bits still to be sent, aligned so the next one sits at the output end
    generate
        if (MSB_FIRST) begin : g_msb
            assign first_bit  = load_data[WIDTH-1];
            assign load_rest  = {load_data[WIDTH-2:0], 1'b0};
            assign next_bit   = shreg[WIDTH-1];
            assign shift_rest = {shreg[WIDTH-2:0], 1'b0};
        end else begin : g_lsb
            assign first_bit  = load_data[0];
            assign load_rest  = {1'b0, load_data[WIDTH-1:1]};
            assign next_bit   = shreg[0];
            assign shift_rest = {1'b0, shreg[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            serial_out <= 1'b0;
`ifdef PISO_PARITY_EN
            parity     <= 1'b0;
`endif
        end else if (accept) begin
            state      <= SHIFT;
            cnt        <= '0;
            serial_out <= first_bit;
            shreg      <= load_rest;
`ifdef PISO_PARITY_EN
            parity     <= ^load_data;
`endif
        end else if (last_bit) begin
            state      <= IDLE;
            cnt        <= '0;
            serial_out <= 1'b0;
        end else if (state == SHIFT) begin
            cnt   <= cnt + CW'(1);
            shreg <= shift_rest;
`ifdef PISO_PARITY_EN
            serial_out <= (cnt == DATA_LAST) ? parity : next_bit;
`else
            serial_out <= next_bit;
`endif
        end
    end

endmodule

// File: doc/piso_tx_serializer.md
Name: piso_tx_serializer

Overview:
Parallel-in/serial-out transmitter that sits directly upstream of siso_reg and drives its serial_in.
- Accepts a WIDTH-bit word through a valid/ready handshake.
- Shifts the word out one bit per clk, with a frame-active flag and an end-of-frame pulse.
- Supports back-to-back words with no idle gap, so siso_reg sees a continuous bit stream.

Parameters:
- WIDTH, 4, data bits per frame; legal range is WIDTH >= 2.
- MSB_FIRST, 1, 1 sends load_data[WIDTH-1] first; 0 sends load_data[0] first.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- load_data  in  WIDTH  parallel word; sampled only on an accepting edge.
- load_valid  in  1  upstream has a word on load_data.
- load_ready  out  1  block can accept a word this cycle.
- serial_out  out  1  serial bit stream; connects to siso_reg serial_in.
- frame_active  out  1  high while serial_out carries a frame bit.
- done  out  1  one-cycle pulse concurrent with the last bit of a frame.

Behaviour:
Reset (asynchronous, active-high):
- State=IDLE, shift register=0, bit counter=0.
- serial_out=0, frame_active=0, done=0, load_ready=1.

States: IDLE, SHIFT. Counter width is $clog2(WIDTH+1).

Acceptance:
- A word is accepted on a rising edge where load_valid && load_ready.
- load_ready is a combinational decode of registered state only, never of load_valid: high in IDLE, or in SHIFT when counter==FRAME_LEN-1 (last-bit cycle).

Timing:
- Registered output. After the accepting edge, bit 0 of the frame appears on serial_out for exactly one cycle, then bit 1, and so on.
- Latency from acceptance to first bit is 1 cycle.

IDLE:
- serial_out=0, frame_active=0.
- Accept → SHIFT, counter=0, first bit driven.

SHIFT:
- frame_active=1. Each edge advances one bit and counter+1.
- At counter==FRAME_LEN-1, done=1.
- At the next edge, if a word is accepted: reload, counter=0, stay in SHIFT (zero-gap back-to-back). Otherwise go to IDLE with serial_out=0.

Boundary conditions:
- load_valid while busy (not the last-bit cycle) is ignored. Upstream must hold load_data and load_valid until load_ready.
- A load_data change while not accepting has no effect.
- Reset mid-frame aborts immediately: the frame is lost, no done pulse, outputs return to reset values asynchronously.
- FRAME_LEN = WIDTH (plus 1 with PARITY_EN).

Optional Feature:
PIS0_PARITY_EN is not used; the macro is PISO_PARITY_EN.
- Defined: FRAME_LEN=WIDTH+1. After the data bits, one even-parity bit (XOR of the accepted word) is sent. done and load_ready assert on the parity-bit cycle.
- Undefined: FRAME_LEN=WIDTH, no parity logic is synthesized, and done aligns with the last data bit.

Decomposition:
Package piso_pkg holds:
- typedef enum logic {IDLE, SHIFT} piso_state_t.
- A function returning FRAME_LEN from WIDTH and the macro.

No sub-module is natural; the block is a single module. The parity XOR is a reduction expression inline.

Test Plan:
1. WIDTH=4, MSB_FIRST=1. Reset, release, present 4'b1011 with load_valid=1 for one accepting edge. serial_out=1,0,1,1 on cycles 1..4. frame_active=1 on cycles 1..4. done=1 on cycle 4 only. Then serial_out=0 and load_ready=1.
2. Back-to-back: 4'b1011 accepted, then 4'b0110 held valid and accepted at the last-bit edge. serial_out=1,0,1,1,0,1,1,0 contiguously. done pulses on cycles 4 and 8. frame_active never drops.
3. MSB_FIRST=0, word 4'b0001. serial_out=1,0,0,0.
4. Busy ignore: accept 4'b1111, then drive load_valid=1 with 4'b0000 during cycles 1..3. load_ready=0 on cycles 1..3 and the stream stays 1,1,1,1. 4'b0000 is accepted only at the cycle-4 edge.
5. Reset mid-frame: accept 4'b1011 and assert rst during bit 2. Outputs go to reset values asynchronously with no done pulse. After release, a fresh 4'b0101 is sent correctly.
6. PISO_PARITY_EN defined, word 4'b1011. serial_out=1,0,1,1,1 (parity=1). done=1 on cycle 5. 4'b1001 ends with parity bit 0.
